// File: rtl/rawdns_pkg.sv
// Shared definitions for the RAWDNS line buffer.
// Holds the default geometry constants, the bank-size derivation and the
// modulo pointer helpers. Line pointers always wrap modulo the bank size,
// which is generally not a power of two, so plain truncation is never
// used for pointer arithmetic.
package rawdns_pkg;

    localparam int DEF_ADDR_WIDTH   = 12;
    localparam int DEF_DATA_WIDTH   = 12;
    localparam int DEF_BLOCK_RADIUS = 2;
    localparam int DEF_WIN_RADIUS   = 6;

    // Number of lines the bank must hold for a given block/window radius.
    function automatic int sram_size(input int block_radius, input int win_radius);
        return 2 * (block_radius + win_radius + 1);
    endfunction

    // Next line pointer, wrapping at size.
    function automatic int ptr_inc(input int ptr, input int size);
        return (ptr + 1 >= size) ? 0 : ptr + 1;
    endfunction

    // Line pointer k lines older than ptr, wrapping at size.
    function automatic int ptr_sub(input int ptr, input int k, input int size);
        return (ptr + size - (k % size)) % size;
    endfunction

endpackage

// File: rtl/line_rotator.sv
// Line rotator: turns the physically ordered SRAM read word into a
// time-ordered vertical column.
// Ports:
//   sram_data   in  SRAM_SIZE*DATA_WIDTH  read word, slot l = line l of the bank
//   bypass_pix  in  DATA_WIDTH            pixel written in the same cycle as the read
//   wr_ptr_d    in  PTR_W                 line that pixel was written to
//   col         out SRAM_SIZE*DATA_WIDTH  slice k = row (y-k), slice 0 newest
module line_rotator
    import rawdns_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SRAM_SIZE  = sram_size(DEF_BLOCK_RADIUS, DEF_WIN_RADIUS),
    parameter int PTR_W      = $clog2(SRAM_SIZE)
)(
    input  logic [SRAM_SIZE*DATA_WIDTH-1:0] sram_data,
    input  logic [DATA_WIDTH-1:0]           bypass_pix,
    input  logic [PTR_W-1:0]                wr_ptr_d,
    output logic [SRAM_SIZE*DATA_WIDTH-1:0] col
);

    // The slot being written returned stale data, so slice 0 always comes
    // from the bypass path; older rows are picked counting back from it.
    always_comb begin
        col = '0;
        col[DATA_WIDTH-1:0] = bypass_pix;
        for (int k = 1; k < SRAM_SIZE; k++) begin
            col[k*DATA_WIDTH +: DATA_WIDTH] =
                sram_data[ptr_sub(int'(wr_ptr_d), k, SRAM_SIZE)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/sram_line_ctrl.sv
// SRAM line buffer controller for the RAWDNS denoiser.
// Writes each accepted raster pixel into the current line of the bank,
// reads the same column from every line and emits a time-ordered column
// two cycles later once all slices hold real rows.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   sof_i          start of frame, qualified by pix_vld_i
//   pix_vld_i      input pixel valid (gaps allowed)
//   pix_i          input pixel
//   sram_addr_o    shared read/write column address
//   sram_wren_o    one-hot write enable of the current line
//   sram_rden_o    read enable, all lines on accepted pixels
//   sram_pix_o     write data
//   sram_data_i    read data, one cycle registered latency
//   col_vld_o      output column valid
//   col_o          column, slice k = row (y-k)
//   col_x_o        column index of the output
//   col_y_o        row of slice 0
//   eof_o          pulse with the last column of the frame
//   frame_err_o    sticky, frame restarted before it completed
module sram_line_ctrl
    import rawdns_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int BLOCK_RADIUS = DEF_BLOCK_RADIUS,
    parameter int WIN_RADIUS   = DEF_WIN_RADIUS,
    parameter int IMG_WIDTH    = 4096,
    parameter int IMG_HEIGHT   = 3072,
    localparam int SRAM_SIZE   = sram_size(BLOCK_RADIUS, WIN_RADIUS)
)(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sof_i,
    input  logic                            pix_vld_i,
    input  logic [DATA_WIDTH-1:0]           pix_i,
    output logic [ADDR_WIDTH-1:0]           sram_addr_o,
    output logic [SRAM_SIZE-1:0]            sram_wren_o,
    output logic [SRAM_SIZE-1:0]            sram_rden_o,
    output logic [DATA_WIDTH-1:0]           sram_pix_o,
    input  logic [SRAM_SIZE*DATA_WIDTH-1:0] sram_data_i,
    output logic                            col_vld_o,
    output logic [SRAM_SIZE*DATA_WIDTH-1:0] col_o,
    output logic [ADDR_WIDTH-1:0]           col_x_o,
    output logic [15:0]                     col_y_o,
    output logic                            eof_o,
    output logic                            frame_err_o
);

    localparam int                    PTR_W        = $clog2(SRAM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] X_LAST       = ADDR_WIDTH'(IMG_WIDTH - 1);
    localparam logic [15:0]           Y_LAST       = 16'(IMG_HEIGHT - 1);
    localparam logic [15:0]           Y_FIRST_EMIT = 16'(SRAM_SIZE - 1);

    logic [ADDR_WIDTH-1:0] x;
    logic [15:0]           y;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  active;

    logic                  start;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] cur_x;
    logic [15:0]           cur_y;
    logic [PTR_W-1:0]      cur_ptr;
    logic                  last_col;
    logic                  last_row;

    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_pix;
    logic [PTR_W-1:0]      s1_ptr;
    logic [ADDR_WIDTH-1:0] s1_x;
    logic [15:0]           s1_y;
    logic                  s1_eof;
    logic                  s1_emit;

    logic [SRAM_SIZE*DATA_WIDTH-1:0] rot_col;

    // S0: a start-of-frame pixel sees the counters as if already cleared,
    // so pixel (0,0) is written in the same cycle sof_i arrives.
    always_comb begin
        start       = sof_i & pix_vld_i;
        accept      = pix_vld_i & (active | sof_i);
        cur_x       = start ? '0 : x;
        cur_y       = start ? '0 : y;
        cur_ptr     = start ? '0 : wr_ptr;
        last_col    = (cur_x == X_LAST);
        last_row    = (cur_y == Y_LAST);
        sram_addr_o = '0;
        sram_wren_o = '0;
        sram_rden_o = '0;
        sram_pix_o  = '0;
        if (accept) begin
            sram_addr_o = cur_x;
            sram_wren_o = SRAM_SIZE'(1) << cur_ptr;
            sram_rden_o = '1;
            sram_pix_o  = pix_i;
        end
    end

    // Raster counters and frame state; the frame closes itself after the
    // last pixel so stray valids without sof_i are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            wr_ptr      <= '0;
            active      <= 1'b0;
            frame_err_o <= 1'b0;
        end else if (accept) begin
            if (start && active) begin
                frame_err_o <= 1'b1;
            end
            if (last_col) begin
                x      <= '0;
                y      <= cur_y + 16'd1;
                wr_ptr <= PTR_W'(ptr_inc(int'(cur_ptr), SRAM_SIZE));
                active <= !last_row;
            end else begin
                x      <= cur_x + ADDR_WIDTH'(1);
                y      <= cur_y;
                wr_ptr <= cur_ptr;
                active <= 1'b1;
            end
        end
    end

    // S1: pixel attributes wait alongside the one-cycle SRAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_pix <= '0;
            s1_ptr <= '0;
            s1_x   <= '0;
            s1_y   <= '0;
            s1_eof <= 1'b0;
        end else begin
            s1_vld <= accept;
            s1_pix <= pix_i;
            s1_ptr <= cur_ptr;
            s1_x   <= cur_x;
            s1_y   <= cur_y;
            s1_eof <= last_col & last_row;
        end
    end

    assign s1_emit = s1_vld && (s1_y >= Y_FIRST_EMIT);

    line_rotator #(
        .DATA_WIDTH (DATA_WIDTH),
        .SRAM_SIZE  (SRAM_SIZE),
        .PTR_W      (PTR_W)
    ) u_rotator (
        .sram_data  (sram_data_i),
        .bypass_pix (s1_pix),
        .wr_ptr_d   (s1_ptr),
        .col        (rot_col)
    );

    // S2: output register; columns of rows still filling the bank are
    // dropped here, so col_o only changes on emitted columns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_vld_o <= 1'b0;
            col_o     <= '0;
            col_x_o   <= '0;
            col_y_o   <= '0;
            eof_o     <= 1'b0;
        end else begin
            col_vld_o <= s1_emit;
            eof_o     <= s1_emit & s1_eof;
            if (s1_emit) begin
                col_o   <= rot_col;
                col_x_o <= s1_x;
                col_y_o <= s1_y;
            end
        end
    end

endmodule

// File: tb/tb_sram_line_ctrl.sv
// Self-checking bench for sram_line_ctrl with a behavioural SRAM bank.
// The reference keeps the whole frame as an image array and predicts each
// column directly from the pixels sent, rows counted back from the current.
module tb_sram_line_ctrl;

    localparam int AW = 12;
    localparam int DW = 12;
    localparam int BR = 2;
    localparam int WR = 6;
    localparam int W  = 8;
    localparam int H  = 20;
    localparam int SS = 2 * (BR + WR + 1);
    localparam int CW = SS * DW;

    typedef logic [255:0] w_t;

    typedef struct {
        int            due;
        logic [CW-1:0] col;
        int            x;
        int            y;
        bit            eof;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sof_i = 1'b0;
    logic          pix_vld_i = 1'b0;
    logic [DW-1:0] pix_i = '0;
    logic [AW-1:0] sram_addr_o;
    logic [SS-1:0] sram_wren_o;
    logic [SS-1:0] sram_rden_o;
    logic [DW-1:0] sram_pix_o;
    logic [CW-1:0] sram_data_i;
    logic          col_vld_o;
    logic [CW-1:0] col_o;
    logic [AW-1:0] col_x_o;
    logic [15:0]   col_y_o;
    logic          eof_o;
    logic          frame_err_o;

    always #5 clk = ~clk;

    sram_line_ctrl #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .BLOCK_RADIUS (BR),
        .WIN_RADIUS   (WR),
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sof_i       (sof_i),
        .pix_vld_i   (pix_vld_i),
        .pix_i       (pix_i),
        .sram_addr_o (sram_addr_o),
        .sram_wren_o (sram_wren_o),
        .sram_rden_o (sram_rden_o),
        .sram_pix_o  (sram_pix_o),
        .sram_data_i (sram_data_i),
        .col_vld_o   (col_vld_o),
        .col_o       (col_o),
        .col_x_o     (col_x_o),
        .col_y_o     (col_y_o),
        .eof_o       (eof_o),
        .frame_err_o (frame_err_o)
    );

    // Behavioural bank: registered read, a slot written in the same cycle
    // returns 0xFFF instead of its content.
    logic [DW-1:0] mem [SS][W];
    logic [CW-1:0] sram_rd = '0;
    assign sram_data_i = sram_rd;

    initial begin
        for (int l = 0; l < SS; l++)
            for (int c = 0; c < W; c++)
                mem[l][c] = '0;
    end

    always @(posedge clk) begin
        for (int l = 0; l < SS; l++) begin
            if (sram_rden_o[l])
                sram_rd[l*DW +: DW] <= sram_wren_o[l] ? DW'(12'hFFF) : mem[l][sram_addr_o[2:0]];
            if (sram_wren_o[l])
                mem[l][sram_addr_o[2:0]] <= sram_pix_o;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_checks = 0;
    int            n_errors = 0;
    int            m_x = 0;
    int            m_y = 0;
    bit            m_active = 1'b0;
    int            img [H][W];
    exp_t          expq [$];
    bit            cmp_en = 1'b0;
    int            vld_count = 0;
    logic [CW-1:0] obs [H][W];
    bit            eof_seen = 1'b0;
    int            eof_x = 0;
    int            eof_y = 0;

    task automatic checkOutput(input string name, input w_t act, input w_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of input; also checks the combinational S0 outputs and
    // queues the column the frame model says must come out two cycles later.
    task automatic applyStimulus(input bit vld, input bit sof);
        bit   acc;
        int   px;
        int   py;
        exp_t e;
        @(posedge clk);
        #1;
        acc = vld && (m_active || sof);
        if (vld && sof) begin
            m_x = 0;
            m_y = 0;
            m_active = 1'b1;
        end
        px = m_x;
        py = m_y;
        sof_i     = sof;
        pix_vld_i = vld;
        pix_i     = acc ? DW'(py * 16 + px) : DW'($urandom);
        #1;
        checkOutput("s0_wren", w_t'(sram_wren_o), acc ? (w_t'(1) << (py % SS)) : w_t'(0));
        checkOutput("s0_rden", w_t'(sram_rden_o), acc ? w_t'({SS{1'b1}}) : w_t'(0));
        checkOutput("s0_addr", w_t'(sram_addr_o), acc ? w_t'(px) : w_t'(0));
        checkOutput("s0_pix",  w_t'(sram_pix_o),  acc ? w_t'(py * 16 + px) : w_t'(0));
        if (acc) begin
            img[py][px] = py * 16 + px;
            if (py >= SS - 1) begin
                e.due = cyc + 2;
                e.x   = px;
                e.y   = py;
                e.eof = (px == W - 1) && (py == H - 1);
                e.col = '0;
                for (int k = 0; k < SS; k++)
                    e.col[k*DW +: DW] = DW'(img[py-k][px]);
                expq.push_back(e);
            end
            m_x++;
            if (m_x == W) begin
                m_x = 0;
                m_y++;
                if (m_y == H) m_active = 1'b0;
            end
        end
    endtask

    task automatic sendPixels(input int n, input bit gaps, input bit with_sof);
        for (int i = 0; i < n; i++) begin
            if (gaps)
                for (int g = 0; g < 8 && $urandom_range(0, 1) == 0; g++)
                    applyStimulus(1'b0, 1'b0);
            applyStimulus(1'b1, with_sof && (i == 0));
        end
    endtask

    task automatic drain();
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("queue_drained", w_t'(expq.size()), w_t'(0));
    endtask

    task automatic clearObs();
        vld_count = 0;
        eof_seen  = 1'b0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                obs[r][c] = '0;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_col_vld",   w_t'(col_vld_o),   w_t'(0));
        checkOutput("rst_eof",       w_t'(eof_o),       w_t'(0));
        checkOutput("rst_frame_err", w_t'(frame_err_o), w_t'(0));
        checkOutput("rst_wren",      w_t'(sram_wren_o), w_t'(0));
        checkOutput("rst_rden",      w_t'(sram_rden_o), w_t'(0));
        checkOutput("rst_addr",      w_t'(sram_addr_o), w_t'(0));
        checkOutput("rst_sram_pix",  w_t'(sram_pix_o),  w_t'(0));
        checkOutput("rst_col_x",     w_t'(col_x_o),     w_t'(0));
        checkOutput("rst_col_y",     w_t'(col_y_o),     w_t'(0));
        checkOutput("rst_col",       w_t'(col_o),       w_t'(0));
    endtask

    task automatic checkSlice(input string name, input int r, input int c, input int k, input int exp);
        logic [CW-1:0] t;
        t = obs[r][c];
        checkOutput(name, w_t'(t[k*DW +: DW]), w_t'(exp));
    endtask

    // Per-cycle compare: a column must appear exactly on its due cycle and
    // nowhere else.
    exp_t cur_e;
    bit   due_now;
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            due_now = (expq.size() > 0) && (expq[0].due == cyc);
            checkOutput("col_vld", w_t'(col_vld_o), w_t'(due_now));
            if (due_now) begin
                cur_e = expq.pop_front();
                checkOutput("col_data", w_t'(col_o),   w_t'(cur_e.col));
                checkOutput("col_x",    w_t'(col_x_o), w_t'(cur_e.x));
                checkOutput("col_y",    w_t'(col_y_o), w_t'(cur_e.y));
                checkOutput("eof",      w_t'(eof_o),   w_t'(cur_e.eof));
                vld_count++;
                obs[cur_e.y][cur_e.x] = col_o;
                if (eof_o) begin
                    eof_seen = 1'b1;
                    eof_x = int'(col_x_o);
                    eof_y = int'(col_y_o);
                end
            end else begin
                checkOutput("eof_idle", w_t'(eof_o), w_t'(0));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs();
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        $display("[TB] full frame without gaps");
        clearObs();
        sendPixels(W * H, 1'b0, 1'b1);
        drain();
        checkOutput("t1_col_count", w_t'(vld_count), w_t'(24));
        checkSlice("t1_r17_k0",  17, 0, 0,  272);
        checkSlice("t1_r17_k5",  17, 0, 5,  192);
        checkSlice("t1_r17_k17", 17, 0, 17, 0);
        checkSlice("t2_r18_k17", 18, 0, 17, 16);
        checkSlice("t2_r18x7_k0", 18, 7, 0, 295);
        checkOutput("t1_eof_seen", w_t'(eof_seen), w_t'(1));
        checkOutput("t1_eof_x", w_t'(eof_x), w_t'(7));
        checkOutput("t1_eof_y", w_t'(eof_y), w_t'(19));
        checkOutput("t1_frame_err", w_t'(frame_err_o), w_t'(0));

        $display("[TB] full frame with random gaps");
        clearObs();
        sendPixels(W * H, 1'b1, 1'b1);
        drain();
        checkOutput("t3_col_count", w_t'(vld_count), w_t'(24));
        checkSlice("t3_r17x3_k2", 17, 3, 2, 243);
        checkSlice("t3_r19x6_k1", 19, 6, 1, 294);
        checkOutput("t3_frame_err", w_t'(frame_err_o), w_t'(0));

        $display("[TB] restart mid-frame");
        sendPixels(5 * W + 2, 1'b0, 1'b1);
        clearObs();
        sendPixels(W * H, 1'b0, 1'b1);
        drain();
        checkOutput("t5_frame_err", w_t'(frame_err_o), w_t'(1));
        checkOutput("t5_col_count", w_t'(vld_count), w_t'(24));
        checkSlice("t5_r17_k0", 17, 0, 0, 272);

        $display("[TB] reset mid-frame");
        sendPixels(18 * W + 3, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        sof_i     = 1'b0;
        pix_vld_i = 1'b1;
        pix_i     = DW'(18 * 16 + 3);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs();
        expq.delete();
        m_active = 1'b0;
        repeat (2) applyStimulus(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (10) applyStimulus(1'b1, 1'b0);
        drain();
        checkOutput("t6_frame_err", w_t'(frame_err_o), w_t'(0));
        checkOutput("t6_col_vld", w_t'(col_vld_o), w_t'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
